// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with optional parity,
// 1/1.5/2 stop bits, majority-vote sampling and error flags.
module uart_rx_cfg #(
   parameter int DBIT    = 8,
   parameter int OVS     = 16,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_s_tick,
   input  logic            i_rx,
   input  logic            i_rx_rd,
   output logic [DBIT-1:0] o_rx_dout,
   output logic            o_rx_valid,
   output logic            o_rx_done_tick,
   output logic            o_parity_err,
   output logic            o_frame_err,
   output logic            o_break_det,
   output logic            o_overrun_err
);

   localparam int MAXC = (SB_TICK > OVS) ? SB_TICK : OVS;
   localparam int SW   = $clog2(MAXC);
   localparam int NW   = $clog2(DBIT + 1);

   localparam logic [SW-1:0] S_TOP  = SW'(OVS - 1);
   localparam logic [SW-1:0] S_V0   = SW'(OVS - 3);
   localparam logic [SW-1:0] S_V1   = SW'(OVS - 2);
   localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_SB   = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PAR, STOP
   } state_t;

   state_t          r_state, w_state;
   logic [SW-1:0]   r_s, w_s;
   logic [NW-1:0]   r_n, w_n;
   logic [DBIT-1:0] r_b, w_b;
   logic            r_p, w_p;
   logic            r_stop, w_stop;
   logic            w_done;

   logic            r_rx_m, r_rx_s;
   logic            r_v0, r_v1;
   logic            w_v;
   logic            w_stop_bit;
   logic            w_perr;
   logic            w_brk;

   logic [DBIT-1:0] r_dout;
   logic            r_valid;
   logic            r_done;
   logic            r_perr;
   logic            r_ferr;
   logic            r_brk;
   logic            r_ovr;

   // 2-of-3 vote over the samples at OVS-3, OVS-2 and the live one
   assign w_v = (r_v0 & r_v1) | (r_v0 & r_rx_s) | (r_v1 & r_rx_s);

   // stop bit may be voted on the same tick that ends the frame
   assign w_stop_bit = (r_s == S_TOP) ? w_v : r_stop;

   assign w_perr = (PARITY == 1) ? (^r_b ^ r_p)
                 : (PARITY == 2) ? ~(^r_b ^ r_p)
                 : 1'b0;

   assign w_brk = (r_b == '0) && ((PARITY == 0) || !r_p)
                  && !w_stop_bit;

   // line synchroniser and vote sample capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
         r_v0   <= 1'b1;
         r_v1   <= 1'b1;
      end else begin
         r_rx_m <= i_rx;
         r_rx_s <= r_rx_m;
         if (i_s_tick && r_s == S_V0) r_v0 <= r_rx_s;
         if (i_s_tick && r_s == S_V1) r_v1 <= r_rx_s;
      end
   end

   // frame state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_s     <= '0;
         r_n     <= '0;
         r_b     <= '0;
         r_p     <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_s     <= w_s;
         r_n     <= w_n;
         r_b     <= w_b;
         r_p     <= w_p;
         r_stop  <= w_stop;
      end
   end

   // next-state logic; each state exits on its terminal s_tick
   always_comb begin
      w_state = r_state;
      w_s     = r_s;
      w_n     = r_n;
      w_b     = r_b;
      w_p     = r_p;
      w_stop  = r_stop;
      w_done  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!r_rx_s) begin
               w_s     = '0;
               w_state = START;
            end
         end
         START: begin
            if (i_s_tick) begin
               if (r_s == S_HALF) begin
                  if (r_rx_s) begin
                     w_state = IDLE;
                  end else begin
                     w_s     = '0;
                     w_n     = '0;
                     w_state = DATA;
                  end
               end else begin
                  w_s = r_s + SW'(1);
               end
            end
         end
         DATA: begin
            if (i_s_tick) begin
               if (r_s == S_TOP) begin
                  w_s = '0;
                  w_b = {w_v, r_b[DBIT-1:1]};
                  if (r_n == N_LAST) begin
                     w_state = (PARITY != 0) ? PAR : STOP;
                  end else begin
                     w_n = r_n + NW'(1);
                  end
               end else begin
                  w_s = r_s + SW'(1);
               end
            end
         end
         PAR: begin
            if (i_s_tick) begin
               if (r_s == S_TOP) begin
                  w_s     = '0;
                  w_p     = w_v;
                  w_state = STOP;
               end else begin
                  w_s = r_s + SW'(1);
               end
            end
         end
         STOP: begin
            if (i_s_tick) begin
               if (r_s == S_TOP) w_stop = w_v;
               if (r_s == S_SB) begin
                  w_s     = '0;
                  w_done  = 1'b1;
                  w_state = IDLE;
               end else begin
                  w_s = r_s + SW'(1);
               end
            end
         end
         default: w_state = IDLE;
      endcase
   end

   // output holding register, error flags and overrun tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_brk   <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_done <= w_done;
         if (w_done) begin
            r_dout  <= r_b;
            r_valid <= 1'b1;
            r_perr  <= w_perr;
            r_ferr  <= ~w_stop_bit;
            r_brk   <= w_brk;
            if (i_rx_rd) r_ovr <= 1'b0;
            else         r_ovr <= r_ovr | r_valid;
         end else if (i_rx_rd && r_valid) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
         end
      end
   end

   assign o_rx_dout      = r_dout;
   assign o_rx_valid     = r_valid;
   assign o_rx_done_tick = r_done;
   assign o_parity_err   = r_perr;
   assign o_frame_err    = r_ferr;
   assign o_break_det    = r_brk;
   assign o_overrun_err  = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for three uart_rx_cfg builds
// (8N1, 8E1, 7O2) driven by a behavioural serial transmitter.
module tb_uart_rx_cfg;

   localparam int OVS = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic s_tick = 1'b0;
   int   tdiv   = 0;
   always @(posedge clk) begin
      tdiv   <= (tdiv == 2) ? 0 : tdiv + 1;
      s_tick <= (tdiv == 2);
   end

   logic [2:0] rst, rx, rd;
   logic [2:0] valid, done, perr, ferr, brk, ovr;
   logic [7:0] dout0, dout1;
   logic [6:0] dout2;
   logic [8:0] dw [3];

   assign dw[0] = {1'b0, dout0};
   assign dw[1] = {1'b0, dout1};
   assign dw[2] = {2'b0, dout2};

   uart_rx_cfg #(
      .DBIT(8), .OVS(OVS), .SB_TICK(16), .PARITY(0)
   ) u0 (
      .clk(clk), .reset(rst[0]), .i_s_tick(s_tick),
      .i_rx(rx[0]), .i_rx_rd(rd[0]), .o_rx_dout(dout0),
      .o_rx_valid(valid[0]), .o_rx_done_tick(done[0]),
      .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
      .o_break_det(brk[0]), .o_overrun_err(ovr[0])
   );

   uart_rx_cfg #(
      .DBIT(8), .OVS(OVS), .SB_TICK(16), .PARITY(1)
   ) u1 (
      .clk(clk), .reset(rst[1]), .i_s_tick(s_tick),
      .i_rx(rx[1]), .i_rx_rd(rd[1]), .o_rx_dout(dout1),
      .o_rx_valid(valid[1]), .o_rx_done_tick(done[1]),
      .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
      .o_break_det(brk[1]), .o_overrun_err(ovr[1])
   );

   uart_rx_cfg #(
      .DBIT(7), .OVS(OVS), .SB_TICK(32), .PARITY(2)
   ) u2 (
      .clk(clk), .reset(rst[2]), .i_s_tick(s_tick),
      .i_rx(rx[2]), .i_rx_rd(rd[2]), .o_rx_dout(dout2),
      .o_rx_valid(valid[2]), .o_rx_done_tick(done[2]),
      .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
      .o_break_det(brk[2]), .o_overrun_err(ovr[2])
   );

   typedef struct {
      int         id;
      logic [8:0] d;
      bit         pe;
      bit         fe;
      bit         bk;
      bit         ov;
   } exp_t;

   exp_t sbq[$];
   int   nchk = 0;
   int   nfail = 0;
   int   ndone [3] = '{0, 0, 0};
   bit   m_valid [3] = '{0, 0, 0};
   bit   m_ovr [3] = '{0, 0, 0};

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      nchk++;
      if (act !== want) begin
         nfail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, want);
      end
   endtask

   // monitor: every completed frame is checked against the queue head
   always @(negedge clk) begin : mon
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (done[i]) begin
            ndone[i]++;
            if (sbq.size() == 0) begin
               nchk++;
               nfail++;
               $display("FAIL unexpected_done: dut %0d, want none", i);
            end else begin
               e = sbq.pop_front();
               chk("dut_id", i, e.id);
               chk("rx_dout", dw[i], e.d);
               chk("rx_valid", valid[i], 1);
               chk("parity_err", perr[i], e.pe);
               chk("frame_err", ferr[i], e.fe);
               chk("break_det", brk[i], e.bk);
               chk("overrun_err", ovr[i], e.ov);
            end
         end
      end
   end

   function automatic bit xr(input logic [8:0] d, input int nb);
      bit r = 0;
      for (int k = 0; k < nb; k++) r ^= d[k];
      return r;
   endfunction

   // reference model: what the receiver must report for a frame
   task automatic expect_frame(input int id, input logic [8:0] d,
                               input int nb, input int pm,
                               input bit p, input bit stop);
      exp_t e;
      logic [8:0] m;
      m    = (9'h1 << nb) - 9'h1;
      e.id = id;
      e.d  = d & m;
      e.pe = (pm == 1) ? (xr(d, nb) ^ p)
           : (pm == 2) ? !(xr(d, nb) ^ p) : 1'b0;
      e.fe = !stop;
      e.bk = (e.d == 0) && (pm == 0 || !p) && !stop;
      e.ov = m_valid[id] | m_ovr[id];
      m_valid[id] = 1'b1;
      m_ovr[id]   = e.ov;
      sbq.push_back(e);
   endtask

   task automatic wait_ticks(input int n);
      int c = 0;
      while (c < n) begin
         @(posedge clk);
         if (s_tick) c++;
      end
      #1;
   endtask

   // serial transmitter; gbit glitches one sample of that data bit,
   // abort resets the DUT at the start of that data bit
   task automatic send_frame(input int id, input logic [8:0] d,
                             input int nb, input int pm,
                             input bit bad_par, input bit stop_lo,
                             input int stop_ticks, input int gbit,
                             input int abort);
      bit p;
      p = xr(d, nb) ^ (pm == 2) ^ bad_par;
      if (abort < 0) expect_frame(id, d, nb, pm, p, !stop_lo);
      rx[id] = 1'b0;
      wait_ticks(OVS);
      for (int k = 0; k < nb; k++) begin
         if (k == abort) begin
            rx[id]  = 1'b1;
            rst[id] = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst[id]     = 1'b0;
            m_valid[id] = 1'b0;
            m_ovr[id]   = 1'b0;
            return;
         end
         rx[id] = d[k];
         if (k == gbit) begin
            wait_ticks(7);
            rx[id] = ~d[k];
            wait_ticks(1);
            rx[id] = d[k];
            wait_ticks(OVS - 8);
         end else begin
            wait_ticks(OVS);
         end
      end
      if (pm != 0) begin
         rx[id] = p;
         wait_ticks(OVS);
      end
      if (stop_lo) begin
         rx[id] = 1'b0;
         wait_ticks(12);
         rx[id] = 1'b1;
         wait_ticks(stop_ticks - 12);
      end else begin
         rx[id] = 1'b1;
         wait_ticks(stop_ticks);
      end
      wait_ticks(OVS + int'($urandom_range(0, 7)));
   endtask

   task automatic do_read(input int id);
      rd[id] = 1'b1;
      @(posedge clk);
      #1;
      rd[id] = 1'b0;
      m_valid[id] = 1'b0;
      m_ovr[id]   = 1'b0;
      chk("valid_after_rd", valid[id], 0);
      chk("overrun_after_rd", ovr[id], 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n0;
      logic [8:0] d;
      int g;
      bit sl;
      rst = 3'b111;
      rx  = 3'b111;
      rd  = 3'b000;
      repeat (4) @(posedge clk);
      #1;
      rst = 3'b000;
      for (int i = 0; i < 3; i++) begin
         chk("reset_valid", valid[i], 0);
         chk("reset_dout", dw[i], 0);
         chk("reset_done", done[i], 0);
         chk("reset_errs", {perr[i], ferr[i], brk[i], ovr[i]}, 0);
      end
      wait_ticks(20);

      // 8N1 basic frame
      n0 = ndone[0];
      send_frame(0, 9'h0A5, 8, 0, 0, 0, 16, -1, -1);
      chk("done_count_a5", ndone[0] - n0, 1);
      do_read(0);

      // overrun
      send_frame(0, 9'h011, 8, 0, 0, 0, 16, -1, -1);
      send_frame(0, 9'h022, 8, 0, 0, 0, 16, -1, -1);
      chk("overrun_sticky", ovr[0], 1);
      chk("overrun_dout", dw[0], 9'h022);
      do_read(0);

      // framing error, then a held-low line
      send_frame(0, 9'h05A, 8, 0, 0, 1, 16, -1, -1);
      do_read(0);
      expect_frame(0, 9'h000, 8, 0, 0, 0);
      expect_frame(0, 9'h0FC, 8, 0, 0, 1);
      rx[0] = 1'b0;
      wait_ticks(200);
      rx[0] = 1'b1;
      wait_ticks(160);
      do_read(0);

      // false start
      n0 = ndone[0];
      rx[0] = 1'b0;
      wait_ticks(4);
      rx[0] = 1'b1;
      wait_ticks(48);
      chk("false_start_no_done", ndone[0] - n0, 0);

      // single-sample glitches inside data bits
      send_frame(0, 9'h0F0, 8, 0, 0, 0, 16, 1, -1);
      send_frame(0, 9'h0F0, 8, 0, 0, 0, 16, 5, -1);
      do_read(0);

      // reset mid-frame
      send_frame(0, 9'h011, 8, 0, 0, 0, 16, -1, -1);
      n0 = ndone[0];
      send_frame(0, 9'h0C3, 8, 0, 0, 0, 16, -1, 3);
      wait_ticks(48);
      chk("abort_no_done", ndone[0] - n0, 0);
      chk("abort_valid", valid[0], 0);
      chk("abort_dout", dw[0], 0);
      chk("abort_errs", {perr[0], ferr[0], brk[0], ovr[0]}, 0);
      send_frame(0, 9'h03C, 8, 0, 0, 0, 16, -1, -1);

      for (int r = 0; r < 20; r++) begin
         d  = 9'($urandom) & 9'h0FF;
         sl = ($urandom_range(0, 3) == 0);
         g  = int'($urandom_range(0, 11));
         if (g > 7) g = -1;
         send_frame(0, d, 8, 0, 0, sl, 16, g, -1);
         if ($urandom_range(0, 1) == 1) do_read(0);
      end

      // even parity
      send_frame(1, 9'h007, 8, 1, 1, 0, 16, -1, -1);
      chk("par_bad_flag", perr[1], 1);
      send_frame(1, 9'h007, 8, 1, 0, 0, 16, -1, -1);
      chk("par_good_flag", perr[1], 0);
      do_read(1);
      for (int r = 0; r < 12; r++) begin
         d = 9'($urandom) & 9'h0FF;
         send_frame(1, d, 8, 1, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0, 16, -1, -1);
         if ($urandom_range(0, 1) == 1) do_read(1);
      end

      // 7 data bits, odd parity, 2 stop bits
      send_frame(2, 9'h0A5, 7, 2, 0, 0, 32, -1, -1);
      chk("odd_par_flag", perr[2], 0);
      do_read(2);
      for (int r = 0; r < 12; r++) begin
         d = 9'($urandom) & 9'h07F;
         send_frame(2, d, 7, 2, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4) == 0, 32, -1, -1);
         if ($urandom_range(0, 1) == 1) do_read(2);
      end

      wait_ticks(40);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
